// File: rtl/score_event_sched.sv
// Turns scoring events into a train of single-cycle score-register increments,
// arbitrating by fixed priority and tracking the ghost chain and extra life.
module score_event_sched #(
   parameter int unsigned PELLET_PTS = 1,
   parameter int unsigned POWER_PTS  = 5,
   parameter int unsigned FRUIT_PTS  = 10,
   parameter int unsigned GHOST_BASE = 20,
   parameter int unsigned EXTRA_AT   = 1000,
   parameter int unsigned PEND_W     = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       clear,
   input  logic       enable,
   input  logic       pellet_eaten,
   input  logic       power_eaten,
   input  logic       ghost_eaten,
   input  logic       fruit_eaten,
   output logic       increment,
   output logic       busy,
   output logic       extra_life,
   output logic [1:0] chain_level
);

   localparam int unsigned AMT_W   = 10;
   localparam int unsigned ISS_W   = 11;
   localparam int unsigned GS_W    = 12;
   localparam int unsigned PW1     = PEND_W + 1;
   localparam int unsigned AMT_MAX = (1 << AMT_W) - 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]       state, state_d;
   logic [PEND_W-1:0] pellet_pend, pellet_pend_d;
   logic [1:0]       power_pend, power_pend_d;
   logic             fruit_pend, fruit_pend_d;
   logic [AMT_W-1:0] ghost_amt, ghost_amt_d;
   logic [AMT_W-1:0] remaining, remaining_d;
   logic [1:0]       chain_d;
   logic [ISS_W-1:0] issued, issued_d;
   logic             extra_done, extra_done_d;

   logic             g_ghost, g_power, g_fruit, g_pellet;
   logic [PW1-1:0]   pellet_sum;
   logic [2:0]       power_sum;
   logic [GS_W-1:0]  ghost_kept, ghost_add, ghost_sum;

   // State register and all counters
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         pellet_pend <= '0;
         power_pend  <= '0;
         fruit_pend  <= 1'b0;
         ghost_amt   <= '0;
         remaining   <= '0;
         chain_level <= '0;
         issued      <= '0;
         extra_done  <= 1'b0;
      end else begin
         state       <= state_d;
         pellet_pend <= pellet_pend_d;
         power_pend  <= power_pend_d;
         fruit_pend  <= fruit_pend_d;
         ghost_amt   <= ghost_amt_d;
         remaining   <= remaining_d;
         chain_level <= chain_d;
         issued      <= issued_d;
         extra_done  <= extra_done_d;
      end
   end

   // Next-state, grant, issue and capture logic
   always_comb begin
      state_d      = state;
      remaining_d  = remaining;
      issued_d     = issued;
      extra_done_d = extra_done;
      g_ghost      = 1'b0;
      g_power      = 1'b0;
      g_fruit      = 1'b0;
      g_pellet     = 1'b0;
      increment    = 1'b0;
      extra_life   = 1'b0;

      case (state)
         IDLE: begin
            if (ghost_amt != '0) begin
               g_ghost     = 1'b1;
               remaining_d = ghost_amt;
               state_d     = RUN;
            end else if (power_pend != '0) begin
               g_power     = 1'b1;
               remaining_d = AMT_W'(POWER_PTS);
               state_d     = RUN;
            end else if (fruit_pend) begin
               g_fruit     = 1'b1;
               remaining_d = AMT_W'(FRUIT_PTS);
               state_d     = RUN;
            end else if (pellet_pend != '0) begin
               g_pellet    = 1'b1;
               remaining_d = AMT_W'(PELLET_PTS);
               state_d     = RUN;
            end
         end
         RUN: begin
            if (enable) begin
               increment   = 1'b1;
               remaining_d = remaining - AMT_W'(1);
               if (issued != '1)
                  issued_d = issued + ISS_W'(1);
               if (issued == ISS_W'(EXTRA_AT - 1) && !extra_done) begin
                  extra_life   = 1'b1;
                  extra_done_d = 1'b1;
               end
               if (remaining == AMT_W'(1))
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Capture combines with a same-cycle grant so no event is lost
      pellet_sum    = {1'b0, pellet_pend} - PW1'(g_pellet) + PW1'(pellet_eaten);
      pellet_pend_d = pellet_sum[PW1-1] ? '1 : pellet_sum[PEND_W-1:0];
      power_sum     = {1'b0, power_pend} - 3'(g_power) + 3'(power_eaten);
      power_pend_d  = power_sum[2] ? 2'b11 : power_sum[1:0];
      fruit_pend_d  = (fruit_pend & ~g_fruit) | fruit_eaten;

      ghost_kept  = g_ghost ? '0 : GS_W'(ghost_amt);
      ghost_add   = ghost_eaten ? (GS_W'(GHOST_BASE) << chain_level) : '0;
      ghost_sum   = ghost_kept + ghost_add;
      ghost_amt_d = (ghost_sum > GS_W'(AMT_MAX)) ? '1 : ghost_sum[AMT_W-1:0];

      // Ghost scores with the old level before a same-cycle power restart
      chain_d = chain_level;
      if (power_eaten)
         chain_d = 2'd0;
      else if (ghost_eaten && chain_level != 2'd3)
         chain_d = chain_level + 2'd1;

      if (clear) begin
         state_d       = IDLE;
         pellet_pend_d = '0;
         power_pend_d  = '0;
         fruit_pend_d  = 1'b0;
         ghost_amt_d   = '0;
         remaining_d   = '0;
         chain_d       = '0;
         issued_d      = '0;
         extra_done_d  = 1'b0;
      end
   end

   assign busy = (state == RUN) | (pellet_pend != '0) | (power_pend != '0) |
                 fruit_pend | (ghost_amt != '0);

endmodule

// File: tb/tb_score_event_sched.sv
// Directed bench for score_event_sched: award lengths, priority, ghost chain,
// enable freeze, extra life and reset/clear behaviour.
module tb_score_event_sched;

   logic       Clk = 1'b0;
   logic       Reset, clear, enable;
   logic       pellet_eaten, power_eaten, ghost_eaten, fruit_eaten;
   logic       increment, busy, extra_life;
   logic [1:0] chain_level;

   int n_checks = 0;
   int n_errors = 0;

   int run_len = 0;
   int runs[$];
   int inc_total = 0;
   int extra_cnt = 0;
   int extra_at  = 0;

   score_event_sched dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .clear        (clear),
      .enable       (enable),
      .pellet_eaten (pellet_eaten),
      .power_eaten  (power_eaten),
      .ghost_eaten  (ghost_eaten),
      .fruit_eaten  (fruit_eaten),
      .increment    (increment),
      .busy         (busy),
      .extra_life   (extra_life),
      .chain_level  (chain_level)
   );

   always #5 Clk = ~Clk;

   // Split increment pulses into award runs and track extra-life timing
   always @(negedge Clk) begin
      if (Reset) begin
         run_len = 0;
      end else begin
         if (increment) begin
            run_len++;
            inc_total++;
         end else if (run_len != 0) begin
            runs.push_back(run_len);
            run_len = 0;
         end
         if (extra_life) begin
            extra_cnt++;
            extra_at = inc_total;
         end
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present events for one clock; returns just after the capturing edge
   task automatic fire(input logic p, input logic pw, input logic g, input logic f);
      pellet_eaten = p;
      power_eaten  = pw;
      ghost_eaten  = g;
      fruit_eaten  = f;
      @(posedge Clk);
      #1;
      pellet_eaten = 1'b0;
      power_eaten  = 1'b0;
      ghost_eaten  = 1'b0;
      fruit_eaten  = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(negedge Clk);
         n++;
      end
      if (busy) check("idle_timeout", 1, 0);
      @(posedge Clk);
      #1;
   endtask

   task automatic check_runs(input string tag, input int exp[$]);
      check({tag, "_count"}, runs.size(), exp.size());
      for (int i = 0; i < exp.size() && i < runs.size(); i++)
         check($sformatf("%s_run%0d", tag, i), runs[i], exp[i]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_runs[$];
      int n, z, m, cyc;
      int g_chain[4];
      int g_award[4];

      Reset = 1'b1; clear = 1'b0; enable = 1'b1;
      pellet_eaten = 1'b0; power_eaten = 1'b0; ghost_eaten = 1'b0; fruit_eaten = 1'b0;
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      @(negedge Clk);
      check("rst_increment", increment, 0);
      check("rst_busy", busy, 0);
      check("rst_extra", extra_life, 0);
      check("rst_chain", chain_level, 0);
      @(posedge Clk); #1;

      // Single pellet: first pulse two cycles after the event
      fire(1, 0, 0, 0);
      @(negedge Clk);
      check("pel_gap_inc", increment, 0);
      check("pel_gap_busy", busy, 1);
      @(negedge Clk);
      check("pel_pulse", increment, 1);
      @(negedge Clk);
      check("pel_after_inc", increment, 0);
      check("pel_after_busy", busy, 0);
      wait_idle(50);
      exp_runs = '{1};
      check_runs("pel", exp_runs);
      runs.delete();

      // Simultaneous pellet, fruit, ghost: priority order
      fire(1, 0, 1, 1);
      wait_idle(100);
      exp_runs = '{20, 10, 1};
      check_runs("prio", exp_runs);
      check("prio_chain", chain_level, 1);

      // Ghost chain, power restart, ghost again
      clear = 1'b1;
      @(posedge Clk); #1 clear = 1'b0;
      runs.delete();
      g_chain = '{1, 2, 3, 3};
      for (int i = 0; i < 4; i++) begin
         fire(0, 0, 1, 0);
         check($sformatf("chain_g%0d", i), chain_level, g_chain[i]);
         wait_idle(300);
      end
      fire(0, 1, 0, 0);
      check("chain_power", chain_level, 0);
      wait_idle(50);
      fire(0, 0, 1, 0);
      check("chain_regh", chain_level, 1);
      wait_idle(50);
      g_award = '{20, 40, 80, 160};
      exp_runs = '{20, 40, 80, 160, 5, 20};
      check_runs("chain", exp_runs);
      runs.delete();

      // Enable freeze during a fruit award after 4 pulses
      fire(0, 0, 0, 1);
      n = 0; cyc = 0;
      while (n < 4 && cyc < 50) begin
         @(negedge Clk);
         if (increment) n++;
         cyc++;
      end
      @(posedge Clk); #1 enable = 1'b0;
      z = 0;
      repeat (5) begin
         @(negedge Clk);
         if (increment) z++;
      end
      check("frz_pulses", z, 0);
      check("frz_busy", busy, 1);
      @(posedge Clk); #1 enable = 1'b1;
      m = 0; cyc = 0;
      while (busy && cyc < 50) begin
         @(negedge Clk);
         if (increment) m++;
         cyc++;
      end
      check("frz_before", n, 4);
      check("frz_after", m, 6);
      @(posedge Clk); #1;
      runs.delete();

      // Extra life: 40 x (ghost 20 + power 5) = 1000 increments
      #2 Reset = 1'b1;
      #3 Reset = 1'b0;
      @(posedge Clk); #1;
      inc_total = 0; extra_cnt = 0; extra_at = 0;
      for (int i = 0; i < 40; i++) begin
         fire(0, 1, 1, 0);
         wait_idle(100);
      end
      check("xl_total", inc_total, 1000);
      check("xl_count", extra_cnt, 1);
      check("xl_at", extra_at, 1000);
      fire(0, 1, 1, 0);
      wait_idle(100);
      check("xl_once", extra_cnt, 1);
      check("xl_total2", inc_total, 1025);
      runs.delete();

      // Async reset mid-run with pellets pending
      fire(1, 0, 1, 0);
      fire(1, 0, 0, 0);
      @(negedge Clk);
      check("ar_running", increment, 1);
      #2 Reset = 1'b1;
      #1;
      check("ar_inc", increment, 0);
      check("ar_busy", busy, 0);
      check("ar_chain", chain_level, 0);
      #3 Reset = 1'b0;
      @(posedge Clk); #1;
      @(negedge Clk);
      check("ar_busy_after", busy, 0);
      @(posedge Clk); #1;

      // Synchronous clear overrides a same-cycle pellet
      fire(1, 0, 1, 0);
      fire(1, 0, 0, 0);
      clear = 1'b1;
      pellet_eaten = 1'b1;
      check("clr_pre_inc", increment, 1);
      @(posedge Clk); #1;
      clear = 1'b0;
      pellet_eaten = 1'b0;
      @(negedge Clk);
      check("clr_inc", increment, 0);
      check("clr_busy", busy, 0);
      check("clr_chain", chain_level, 0);
      @(posedge Clk); #1;
      runs.delete();
      fire(1, 0, 0, 0);
      wait_idle(50);
      exp_runs = '{1};
      check_runs("clr_post", exp_runs);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
